instruction_fetch: RTL and testbench

//   Fetch stage directly downstream of the program counter. Owns the architectural PC

---
 rtl/instruction_fetch.sv | 244 ++++++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the architectural PC and issues word fetches over a
// req/ack handshake. Returned words go into a small FIFO whose head is presented
// to decode as {Instr, InstrPC} with a valid/ready handshake. A Redirect from
// execute reloads the PC and flushes the stage.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined     - a Redirect target with nonzero [1:0] sets a sticky MisalignFault,
//                 parks the fetcher, and loads the PC unmodified.
//   not defined - RedirectPC[1:0] is forced to zero and MisalignFault is absent.
//
// state   | meaning
// --------+--------------------------------------------------------------------
// ST_IDLE | no committed request; issues from PC when the FIFO has space
// ST_REQ  | request to PC is committed and held until IMemAck
// ST_DROP | request to an old address still held; its data is discarded on ack
module instruction_fetch #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    output logic               InstrValid,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    input  logic               DecodeReady
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic               MisalignFault
`endif
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  drop_addr_q, drop_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

    logic [INSTR_W-1:0] fifo_instr_q [BUF_DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_q    [BUF_DEPTH];

    logic               fault_q, fault_d;
    logic [ADDR_W-1:0]  redir_tgt;
    logic               redir_bad;
    logic               req_c;
    logic [ADDR_W-1:0]  addr_c;
    logic               push;
    logic               pop;
    logic               has_space;
    logic [CNT_W-1:0]   cnt_if_push;
    logic               space_if_push;
    logic [PTR_W-1:0]   rd_ptr_nx;
    state_t             resume_st;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_tgt = RedirectPC;
    assign redir_bad = (RedirectPC[1:0] != 2'b00);

    // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
    always_comb begin
        fault_d = fault_q;
        if (Redirect) begin
            fault_d = redir_bad;
        end
    end

    // Fault flag register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign MisalignFault = fault_q;
`else
    logic [1:0] unused_redir_lsb;
    assign unused_redir_lsb = RedirectPC[1:0];
    assign redir_tgt        = {RedirectPC[ADDR_W-1:2], 2'b00};
    assign redir_bad        = 1'b0;
    assign fault_d          = 1'b0;
    assign fault_q          = 1'b0;
`endif

    assign pop           = (count_q != '0) && DecodeReady;
    assign has_space     = (count_q < DEPTH_C);
    assign cnt_if_push   = count_q + CNT_W'(1) - (pop ? CNT_W'(1) : CNT_W'(0));
    assign space_if_push = (cnt_if_push < DEPTH_C);
    assign rd_ptr_nx     = rd_ptr_q + PTR_W'(1);
    assign resume_st     = fault_d ? ST_IDLE : ST_REQ;

    // Fetch FSM: request issue, PC advance and redirect handling.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        req_c       = 1'b0;
        addr_c      = pc_q;
        push        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Redirect) begin
                    pc_d    = redir_tgt;
                    state_d = resume_st;
                end else if (has_space && !fault_q) begin
                    req_c = 1'b1;
                    if (IMemAck) begin
                        push    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = space_if_push ? ST_REQ : ST_IDLE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req_c = 1'b1;
                if (IMemAck) begin
                    if (Redirect) begin
                        pc_d    = redir_tgt;
                        state_d = resume_st;
                    end else begin
                        push    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = space_if_push ? ST_REQ : ST_IDLE;
                    end
                end else if (Redirect) begin
                    pc_d        = redir_tgt;
                    drop_addr_d = pc_q;
                    state_d     = ST_DROP;
                end
            end
            ST_DROP: begin
                req_c  = 1'b1;
                addr_c = drop_addr_q;
                if (Redirect) begin
                    pc_d = redir_tgt;
                end
                if (IMemAck) begin
                    state_d = resume_st;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and registered head output (holds last value when empty).
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (Redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_nx;
            end
            count_d = count_q + (push ? CNT_W'(1) : CNT_W'(0))
                              - (pop  ? CNT_W'(1) : CNT_W'(0));
            if (count_d != '0) begin
                if (pop) begin
                    if (count_q > CNT_W'(1)) begin
                        instr_d    = fifo_instr_q[rd_ptr_nx];
                        instr_pc_d = fifo_pc_q[rd_ptr_nx];
                    end else begin
                        instr_d    = IMemData;
                        instr_pc_d = pc_q;
                    end
                end else if (count_q == '0) begin
                    instr_d    = IMemData;
                    instr_pc_d = pc_q;
                end
            end
        end
    end

    // State, PC and FIFO control registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
        end
    end

    // FIFO storage; entries need no reset since count gates their use.
    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            fifo_instr_q[wr_ptr_q] <= IMemData;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign IMemReq    = req_c & ~Reset;
    assign IMemAddr   = addr_c;
    assign InstrValid = (count_q != '0);
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a vector table for reset/streaming/full-FIFO
// behaviour, short directed sequences for redirect and wrap corners, then
// randomized traffic checked against a queue-based reference model.
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        DecodeReady;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        MisalignFault;
`endif

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
        .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC),
        .DecodeReady(DecodeReady)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .MisalignFault(MisalignFault)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic [31:0] data;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_ipc;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    function automatic vec_t mk(input logic rst, ack, rdy, input logic [31:0] data,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdy = rdy; v.data = data;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei; v.exp_ipc = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge and wait to the sampling point.
    task automatic drive(input logic rst, redir, input logic [31:0] rpc, input logic ack,
                         input logic [31:0] data, input logic rdy);
        Reset = rst; Redirect = redir; RedirectPC = rpc;
        IMemAck = ack; IMemData = data; DecodeReady = rdy;
        @(negedge Clk);
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        adv();
    endtask

    vec_t tbl[17];

    // reference model state
    ent_t        mq[$];
    logic [31:0] m_pc, m_held_addr, m_last_instr, m_last_pc;
    logic        m_held, m_discard, m_sticky, m_fault;

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0; m_held_addr = 32'h0; m_last_instr = 32'h0; m_last_pc = 32'h0;
        m_held = 1'b0; m_discard = 1'b0; m_sticky = 1'b0; m_fault = 1'b0;
    endtask

    initial begin
        logic        r_rst, r_redir, r_ack, r_rdy, m_req, m_acked, m_mis;
        logic [31:0] r_rpc, r_data, m_addr, m_tgt;
        ent_t        e;

        Reset = 1'b1; Redirect = 1'b0; RedirectPC = '0;
        IMemAck = 1'b0; IMemData = '0; DecodeReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // rst ack rdy data | req addr valid instr instrpc
        tbl[0]  = mk(1, 1, 0, 32'hDEAD_0000, 0, 32'h0, 0, 32'h0,         32'h0);
        tbl[1]  = mk(0, 1, 1, 32'hA000_0000, 1, 32'h0, 0, 32'h0,         32'h0);
        tbl[2]  = mk(0, 1, 1, 32'hA000_0001, 1, 32'h4, 1, 32'hA000_0000, 32'h0);
        tbl[3]  = mk(0, 1, 1, 32'hA000_0002, 1, 32'h8, 1, 32'hA000_0001, 32'h4);
        tbl[4]  = mk(0, 1, 1, 32'hA000_0003, 1, 32'hC, 1, 32'hA000_0002, 32'h8);
        tbl[5]  = mk(1, 0, 0, 32'h0,         0, 32'h0, 1, 32'hA000_0003, 32'hC);
        tbl[6]  = mk(0, 1, 0, 32'hB000_0000, 1, 32'h0, 0, 32'h0,         32'h0);
        tbl[7]  = mk(0, 1, 0, 32'hB000_0001, 1, 32'h4, 1, 32'hB000_0000, 32'h0);
        tbl[8]  = mk(0, 1, 0, 32'hDEAD_0008, 0, 32'h0, 1, 32'hB000_0000, 32'h0);
        tbl[9]  = mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'hB000_0000, 32'h0);
        tbl[10] = mk(0, 0, 1, 32'h0,         0, 32'h0, 1, 32'hB000_0000, 32'h0);
        tbl[11] = mk(0, 0, 0, 32'h0,         1, 32'h8, 1, 32'hB000_0001, 32'h4);
        tbl[12] = mk(0, 1, 1, 32'hB000_0002, 1, 32'h8, 1, 32'hB000_0001, 32'h4);
        tbl[13] = mk(0, 0, 1, 32'h0,         1, 32'hC, 1, 32'hB000_0002, 32'h8);
        tbl[14] = mk(0, 0, 0, 32'h0,         1, 32'hC, 0, 32'hB000_0002, 32'h8);
        tbl[15] = mk(1, 1, 0, 32'hDEAD_000F, 0, 32'h0, 0, 32'hB000_0002, 32'h8);
        tbl[16] = mk(0, 0, 0, 32'h0,         1, 32'h0, 0, 32'h0,         32'h0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, 1'b0, 32'h0, tbl[i].ack, tbl[i].data, tbl[i].rdy);
            chk($sformatf("tbl%0d_req", i), {31'b0, IMemReq}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req)
                chk($sformatf("tbl%0d_addr", i), IMemAddr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, InstrValid}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_instr", i), Instr, tbl[i].exp_instr);
            chk($sformatf("tbl%0d_ipc", i), InstrPC, tbl[i].exp_ipc);
            adv();
        end

        // Redirect while a request waits; ack arrives three cycles later.
        do_reset();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("drop_req0", {31'b0, IMemReq}, 32'h1); chk("drop_addr0", IMemAddr, 32'h0); adv();
        drive(0, 1, 32'h100, 0, 32'h0, 1);
        chk("drop_req1", {31'b0, IMemReq}, 32'h1); chk("drop_addr1", IMemAddr, 32'h0); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("drop_addr2", IMemAddr, 32'h0); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("drop_addr3", IMemAddr, 32'h0); adv();
        drive(0, 0, 32'h0, 1, 32'hDEAD_BEEF, 1);
        chk("drop_req4", {31'b0, IMemReq}, 32'h1); chk("drop_addr4", IMemAddr, 32'h0); adv();
        drive(0, 0, 32'h0, 1, 32'hC000_0100, 1);
        chk("drop_valid5", {31'b0, InstrValid}, 32'h0);
        chk("drop_addr5", IMemAddr, 32'h100); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("drop_instr6", Instr, 32'hC000_0100); chk("drop_ipc6", InstrPC, 32'h100);
        chk("drop_addr6", IMemAddr, 32'h104); adv();

        // Redirect coinciding with an ack; then redirect with a full FIFO.
        do_reset();
        drive(0, 0, 32'h0, 1, 32'hC100_0000, 0);
        chk("rack_addr0", IMemAddr, 32'h0); adv();
        drive(0, 1, 32'h100, 1, 32'hDEAD_0004, 0);
        chk("rack_addr1", IMemAddr, 32'h4); chk("rack_valid1", {31'b0, InstrValid}, 32'h1); adv();
        drive(0, 0, 32'h0, 1, 32'hC100_0100, 0);
        chk("rack_valid2", {31'b0, InstrValid}, 32'h0); chk("rack_addr2", IMemAddr, 32'h100); adv();
        drive(0, 0, 32'h0, 1, 32'hC100_0104, 0);
        chk("rack_instr3", Instr, 32'hC100_0100); chk("rack_addr3", IMemAddr, 32'h104); adv();
        drive(0, 1, 32'h200, 0, 32'h0, 1);
        chk("full_req4", {31'b0, IMemReq}, 32'h0); chk("full_valid4", {31'b0, InstrValid}, 32'h1); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        chk("full_valid5", {31'b0, InstrValid}, 32'h0); chk("full_addr5", IMemAddr, 32'h200); adv();

        // PC wrap at the top of the address space.
        do_reset();
        drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1);
        chk("wrap_req0", {31'b0, IMemReq}, 32'h0); adv();
        drive(0, 0, 32'h0, 1, 32'hC200_0000, 1);
        chk("wrap_addr1", IMemAddr, 32'hFFFF_FFFC); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("wrap_addr2", IMemAddr, 32'h0); chk("wrap_ipc2", InstrPC, 32'hFFFF_FFFC); adv();
`ifdef FETCH_MISALIGN_CHECK_EN
        do_reset();
        drive(0, 1, 32'h102, 0, 32'h0, 1);
        chk("mis_fault0", {31'b0, MisalignFault}, 32'h0); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("mis_fault1", {31'b0, MisalignFault}, 32'h1); chk("mis_req1", {31'b0, IMemReq}, 32'h0); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("mis_req2", {31'b0, IMemReq}, 32'h0); adv();
        drive(0, 1, 32'h200, 0, 32'h0, 1);
        chk("mis_req3", {31'b0, IMemReq}, 32'h0); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("mis_fault4", {31'b0, MisalignFault}, 32'h0);
        chk("mis_req4", {31'b0, IMemReq}, 32'h1); chk("mis_addr4", IMemAddr, 32'h200); adv();
`else
        drive(0, 1, 32'h103, 0, 32'h0, 1);
        chk("lsb_addr0", IMemAddr, 32'h0); adv();
        drive(0, 0, 32'h0, 1, 32'hDEAD_0103, 1);
        chk("lsb_addr1", IMemAddr, 32'h0); adv();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("lsb_addr2", IMemAddr, 32'h100); adv();
`endif

        // Randomized traffic against the reference model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            r_rst   = (c == 0) || ($urandom_range(0, 99) == 0);
            r_redir = !r_rst && ($urandom_range(0, 9) == 0);
            r_rpc   = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) r_rpc[1:0] = 2'b00;
            m_tgt = r_rpc;
            m_mis = (r_rpc[1:0] != 2'b00);
`else
            m_tgt = r_rpc & 32'hFFFF_FFFC;
            m_mis = 1'b0;
`endif
            r_rdy  = ($urandom_range(0, 1) == 1);
            r_data = $urandom;
            // A request is made when one is still outstanding, or when there is
            // room and either no redirect arrives or the previous cycle ended
            // with an ack/redirect that commits the next fetch.
            m_req  = !r_rst && (m_held ||
                     (!m_fault && (mq.size() < DEPTH) && (m_sticky || !r_redir)));
            m_addr = m_held ? m_held_addr : m_pc;
            r_ack  = r_rst ? ($urandom_range(0, 1) == 1) : (m_req && ($urandom_range(0, 2) != 0));

            drive(r_rst, r_redir, r_rpc, r_ack, r_data, r_rdy);
            if (c != 0) begin
                chk("rnd_req", {31'b0, IMemReq}, {31'b0, m_req});
                if (m_req) chk("rnd_addr", IMemAddr, m_addr);
                chk("rnd_valid", {31'b0, InstrValid}, {31'b0, (mq.size() != 0)});
                chk("rnd_instr", Instr, m_last_instr);
                chk("rnd_ipc", InstrPC, m_last_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
                chk("rnd_fault", {31'b0, MisalignFault}, {31'b0, m_fault});
`endif
            end

            if (r_rst) begin
                model_reset();
            end else begin
                if ((mq.size() != 0) && r_rdy) void'(mq.pop_front());
                m_acked = m_req && r_ack;
                if (m_acked && !(m_held && m_discard) && !r_redir) begin
                    e.instr = r_data;
                    e.pc    = m_addr;
                    mq.push_back(e);
                    m_pc = m_addr + 32'd4;
                end
                if (r_redir) begin
                    m_pc    = m_tgt;
                    m_fault = m_mis;
                    mq.delete();
                end
                m_discard   = (m_req && !r_ack) && ((m_held && m_discard) || r_redir);
                if (m_req && !r_ack) m_held_addr = m_addr;
                m_held      = m_req && !r_ack;
                m_sticky    = m_acked || r_redir;
                if (mq.size() != 0) begin
                    m_last_instr = mq[0].instr;
                    m_last_pc    = mq[0].pc;
                end
            end
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
